// File: rtl/key_debounce.sv
// key_debounce: synchronizes and debounces an active-low push button, emitting level and edge pulses
// Ports: i_clk clock; i_rst sync active-high reset; i_key_n raw button (0 = pressed);
//        o_key_level debounced level (1 = pressed); o_press_pulse / o_release_pulse one-cycle accepted edges;
//        o_long_press one-cycle pulse after LONGPRESS_CYCLES in PRESSED, only when KEY_LONGPRESS_EN is defined
module key_debounce #(
   parameter int DEBOUNCE_CYCLES  = 500000,
   parameter int LONGPRESS_CYCLES = 50000000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_key_n,
   output logic o_key_level,
   output logic o_press_pulse,
   output logic o_release_pulse,
   output logic o_long_press
);
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;
   state_t state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [1:0] sync;
   logic pressed, press_nx, release_nx;
   assign pressed = ~sync[1];
   always_ff @(posedge i_clk)
      if (i_rst) sync <= 2'b11;
      else sync <= {sync[0], i_key_n};
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      press_nx   = 1'b0;
      release_nx = 1'b0;
      unique case (state)
         RELEASED:
            if (pressed) begin
               state_nx = PRESS_WAIT;
               cnt_nx   = '0;
            end
         PRESS_WAIT:
            if (!pressed) state_nx = RELEASED;
            else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
               state_nx = PRESSED;
               press_nx = 1'b1;
            end else cnt_nx = cnt + 1'b1;
         PRESSED:
            if (!pressed) begin
               state_nx = RELEASE_WAIT;
               cnt_nx   = '0;
            end
         RELEASE_WAIT:
            if (pressed) state_nx = PRESSED;
            else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
               state_nx   = RELEASED;
               release_nx = 1'b1;
            end else cnt_nx = cnt + 1'b1;
         default: state_nx = RELEASED;
      endcase
   end
   always_ff @(posedge i_clk)
      if (i_rst) begin
         state           <= RELEASED;
         cnt             <= '0;
         o_key_level     <= 1'b0;
         o_press_pulse   <= 1'b0;
         o_release_pulse <= 1'b0;
      end else begin
         state           <= state_nx;
         cnt             <= cnt_nx;
         o_key_level     <= press_nx ? 1'b1 : release_nx ? 1'b0 : o_key_level;
         o_press_pulse   <= press_nx;
         o_release_pulse <= release_nx;
      end
`ifdef KEY_LONGPRESS_EN
   localparam int HW = $clog2(LONGPRESS_CYCLES);
   logic [HW-1:0] hold;
   // hold only advances in PRESSED and saturates, so the pulse fires once per accepted press
   always_ff @(posedge i_clk)
      if (i_rst) begin
         hold         <= '0;
         o_long_press <= 1'b0;
      end else begin
         hold         <= press_nx ? '0 : (state == PRESSED && hold != HW'(LONGPRESS_CYCLES - 1)) ? hold + 1'b1 : hold;
         o_long_press <= state == PRESSED && hold == HW'(LONGPRESS_CYCLES - 2);
      end
`else
   assign o_long_press = 1'b0;
`endif
endmodule
